// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: PC-1 on load, C/D rotation per round,
// PC-2 output. Optional weak-key flag under macro DES_WEAK_KEY_DETECT_EN.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] keyIn,
    input  logic        decrypt,
    input  logic        advance,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_idx,
    output logic        last_round,
    output logic        done,
    output logic        weak_key
);

    typedef enum logic {IDLE, RUN} state_e;

    // Key bit numbers are 1-based with bit 1 at keyIn[63].
    localparam byte PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam byte PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-int'(PC1[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-int'(PC2[i])];
        end
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one, all others by two.
    function automatic logic two_shift(input logic [4:0] rnd);
        return !(rnd == 5'd1 || rnd == 5'd2 || rnd == 5'd9 || rnd == 5'd16);
    endfunction

    // Bit 1 of each half sits at index 27, so a DES left shift moves
    // bits toward the MSB.
    function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;

    logic [55:0] cd0;
    logic [4:0]  rnd;
    logic        sh2;

    assign cd0 = pc1(keyIn);

    // DES round number whose shift moves us to the next subkey
    always_comb begin
        rnd = 5'd0;
        if (dir_q) begin
            rnd = 5'd16 - {1'b0, idx_q};
        end else begin
            rnd = {1'b0, idx_q} + 5'd2;
        end
        sh2 = two_shift(rnd);
    end

    // Next-state: load has priority, then advance while running
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = RUN;
            dir_d   = decrypt;
            idx_d   = 4'd0;
            if (decrypt) begin
                c_d = cd0[55:28];
                d_d = cd0[27:0];
            end else begin
                c_d = rotl(cd0[55:28], 1'b0);
                d_d = rotl(cd0[27:0], 1'b0);
            end
        end else if (advance && state_q == RUN) begin
            if (idx_q == 4'd15) begin
                state_d = IDLE;
                idx_d   = 4'd0;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + 4'd1;
                if (dir_q) begin
                    c_d = rotr(c_q, sh2);
                    d_d = rotr(d_q, sh2);
                end else begin
                    c_d = rotl(c_q, sh2);
                    d_d = rotl(d_q, sh2);
                end
            end
        end
    end

    // Schedule state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

`ifdef DES_WEAK_KEY_DETECT_EN
    logic weak_q, weak_d;
    logic c_flat, d_flat;

    assign c_flat = (cd0[55:28] == '0) || (cd0[55:28] == '1);
    assign d_flat = (cd0[27:0] == '0) || (cd0[27:0] == '1);

    // Weak-key flag refreshed on every load from the PC-1 halves
    always_comb begin
        weak_d = weak_q;
        if (load) begin
            weak_d = c_flat && d_flat;
        end
    end

    // Weak-key flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weak_q <= 1'b0;
        end else begin
            weak_q <= weak_d;
        end
    end

    assign weak_key = weak_q;
`else
    assign weak_key = 1'b0;
`endif

    assign subkey       = pc2({c_q, d_q});
    assign subkey_valid = (state_q == RUN);
    assign round_idx    = idx_q;
    assign last_round   = subkey_valid && (idx_q == 4'd15);
    assign done         = done_q;

endmodule
